// File: rtl/spu_reverb_out_mix.sv
// SPU reverb output mixer: scales captured Lout/Rout by the output volumes, adds the dry sums
// and queues stereo frames in a FWFT FIFO. Define SPU_REVERB_OUT_CLAMP_EN to saturate instead of wrap.
module spu_reverb_out_mix #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_reverbValid,
  input  logic                            i_side22Khz,
  input  logic signed [15:0]              i_reverbSample,
  input  logic                            i_ctrlSendOut,
  input  logic                            i_reverbOutEnable,
  input  logic signed [15:0]              i_vLOUT,
  input  logic signed [15:0]              i_vROUT,
  input  logic signed [15:0]              i_dryL,
  input  logic signed [15:0]              i_dryR,
  output logic signed [15:0]              o_sampleL,
  output logic signed [15:0]              o_sampleR,
  output logic                            o_sampleValid,
  input  logic                            i_sampleReady,
  output logic [$clog2(FIFO_DEPTH):0]     o_level,
  output logic                            o_busy,
  output logic                            o_overflow,
  input  logic                            i_clrOverflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, PUSH} state_t;

  state_t             state_q;
  logic signed [15:0] capL_q, capR_q;
  logic signed [15:0] wCapL_q, wCapR_q, wDryL_q, wDryR_q, wVolL_q, wVolR_q;
  logic               wEn_q;
  logic signed [15:0] outL_q, outR_q;
  logic               overflow_q, overflow_d;

  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        level_q, level_d;
  logic               full, pop, push_ok;

  logic signed [15:0] mulA, mulB, dry, wet, mix;
  logic signed [31:0] prod;
  logic signed [16:0] sum;
  logic               unused_prod;

  // Capture runs regardless of the FSM; the frame works from its own snapshot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      capL_q <= '0;
      capR_q <= '0;
    end else if (i_reverbValid) begin
      if (i_side22Khz) capR_q <= i_reverbSample;
      else             capL_q <= i_reverbSample;
    end
  end

`ifdef SPU_REVERB_OUT_CLAMP_EN
  function automatic logic signed [15:0] sat16(input logic signed [16:0] s);
    if (s > 17'sd32767)       return 16'sh7FFF;
    else if (s < -17'sd32768) return 16'sh8000;
    else                      return s[15:0];
  endfunction
`endif

  // One multiplier shared between the LEFT and RIGHT steps.
  always_comb begin
    mulA = (state_q == RIGHT) ? wCapR_q : wCapL_q;
    mulB = (state_q == RIGHT) ? wVolR_q : wVolL_q;
    dry  = (state_q == RIGHT) ? wDryR_q : wDryL_q;
    prod = mulA * mulB;
    wet  = wEn_q ? prod[30:15] : 16'sd0;
    sum  = 17'(dry) + 17'(wet);
`ifdef SPU_REVERB_OUT_CLAMP_EN
    mix  = sat16(sum);
`else
    mix  = sum[15:0];
`endif
  end

`ifdef SPU_REVERB_OUT_CLAMP_EN
  assign unused_prod = ^{prod[31], prod[14:0]};
`else
  assign unused_prod = ^{prod[31], prod[14:0], sum[16]};
`endif

  assign full    = (level_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = (level_q != '0) && i_sampleReady;
  assign push_ok = (state_q == PUSH) && (!full || pop);

  always_comb begin
    overflow_d = overflow_q;
    if (i_clrOverflow) overflow_d = 1'b0;
    // A new drop always wins over a simultaneous clear.
    if ((i_ctrlSendOut && state_q != IDLE) || (state_q == PUSH && full && !pop))
      overflow_d = 1'b1;
    level_d = level_q;
    if (push_ok && !pop)      level_d = level_q + 1'b1;
    else if (!push_ok && pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      wCapL_q    <= '0;
      wCapR_q    <= '0;
      wDryL_q    <= '0;
      wDryR_q    <= '0;
      wVolL_q    <= '0;
      wVolR_q    <= '0;
      wEn_q      <= 1'b0;
      outL_q     <= '0;
      outR_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      case (state_q)
        IDLE: if (i_ctrlSendOut) begin
          state_q <= LEFT;
          wCapL_q <= capL_q;
          wCapR_q <= capR_q;
          wDryL_q <= i_dryL;
          wDryR_q <= i_dryR;
          wVolL_q <= i_vLOUT;
          wVolR_q <= i_vROUT;
          wEn_q   <= i_reverbOutEnable;
        end
        LEFT: begin
          outL_q  <= mix;
          state_q <= RIGHT;
        end
        RIGHT: begin
          outR_q  <= mix;
          state_q <= PUSH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO storage holds data only; the head is gated so an empty FIFO reads as zero.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q] <= {outL_q, outR_q};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      level_q <= level_d;
    end
  end

  assign o_sampleValid = (level_q != '0);
  assign o_sampleL     = o_sampleValid ? mem_q[rd_q][31:16] : 16'sd0;
  assign o_sampleR     = o_sampleValid ? mem_q[rd_q][15:0]  : 16'sd0;
  assign o_level       = level_q;
  assign o_busy        = (state_q != IDLE);
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_spu_reverb_out_mix.sv
// Directed bench for spu_reverb_out_mix; expected samples follow SPU_REVERB_OUT_CLAMP_EN.
module tb_spu_reverb_out_mix;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_reverbValid, i_side22Khz, i_ctrlSendOut, i_reverbOutEnable;
  logic signed [15:0] i_reverbSample, i_vLOUT, i_vROUT, i_dryL, i_dryR;
  logic signed [15:0] o_sampleL, o_sampleR;
  logic               o_sampleValid, i_sampleReady, o_busy, o_overflow, i_clrOverflow;
  logic [2:0]         o_level;

  int errors = 0;
  int checks = 0;

  spu_reverb_out_mix #(.FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_reverbValid(i_reverbValid), .i_side22Khz(i_side22Khz), .i_reverbSample(i_reverbSample),
    .i_ctrlSendOut(i_ctrlSendOut), .i_reverbOutEnable(i_reverbOutEnable),
    .i_vLOUT(i_vLOUT), .i_vROUT(i_vROUT), .i_dryL(i_dryL), .i_dryR(i_dryR),
    .o_sampleL(o_sampleL), .o_sampleR(o_sampleR), .o_sampleValid(o_sampleValid),
    .i_sampleReady(i_sampleReady), .o_level(o_level), .o_busy(o_busy),
    .o_overflow(o_overflow), .i_clrOverflow(i_clrOverflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic side, input logic [15:0] val);
    i_reverbValid = 1'b1; i_side22Khz = side; i_reverbSample = val;
    tick();
    i_reverbValid = 1'b0;
  endtask

  task automatic frame(input logic [15:0] dl, input logic [15:0] dr,
                       input logic [15:0] vl, input logic [15:0] vr, input logic en);
    i_dryL = dl; i_dryR = dr; i_vLOUT = vl; i_vROUT = vr; i_reverbOutEnable = en;
    i_ctrlSendOut = 1'b1;
    tick();
    i_ctrlSendOut = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic pop1();
    i_sampleReady = 1'b1;
    tick();
    i_sampleReady = 1'b0;
  endtask

  initial begin
    logic [15:0] expPos, expNeg;
`ifdef SPU_REVERB_OUT_CLAMP_EN
    expPos = 16'h7FFF; expNeg = 16'h8000;
`else
    expPos = 16'hEFFE; expNeg = 16'h0001;
`endif
    i_rst = 1'b1; i_reverbValid = 0; i_side22Khz = 0; i_reverbSample = 0;
    i_ctrlSendOut = 0; i_reverbOutEnable = 0; i_vLOUT = 0; i_vROUT = 0;
    i_dryL = 0; i_dryR = 0; i_sampleReady = 0; i_clrOverflow = 0;
    tick(); tick();
    chk("rst_valid", 16'(o_sampleValid), 16'h0);
    chk("rst_level", 16'(o_level), 16'h0);
    chk("rst_busy", 16'(o_busy), 16'h0);
    chk("rst_ovf", 16'(o_overflow), 16'h0);
    i_rst = 1'b0;
    tick();

    // Basic mix with latency: 0x1000 + (0x4000*0x4000)>>15 = 0x3000
    capture(1'b0, 16'h4000);
    i_dryL = 16'h1000; i_dryR = 16'h0000; i_vLOUT = 16'h4000; i_vROUT = 16'h0000;
    i_reverbOutEnable = 1'b1; i_ctrlSendOut = 1'b1;
    tick();
    i_ctrlSendOut = 1'b0;
    chk("busy_left", 16'(o_busy), 16'h1);
    tick(); tick();
    chk("valid_early", 16'(o_sampleValid), 16'h0);
    chk("busy_push", 16'(o_busy), 16'h1);
    tick();
    chk("basic_valid", 16'(o_sampleValid), 16'h1);
    chk("basic_busy", 16'(o_busy), 16'h0);
    chk("basic_L", o_sampleL, 16'h3000);
    chk("basic_R", o_sampleR, 16'h0000);
    chk("basic_level", 16'(o_level), 16'h1);
    pop1();
    chk("basic_popped", 16'(o_sampleValid), 16'h0);

    // Positive overflow of the sum
    capture(1'b0, 16'h7FFF);
    frame(16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1);
    chk("pos_L", o_sampleL, expPos);
    pop1();

    // Negative overflow, then wet term disabled
    capture(1'b1, 16'h8000);
    frame(16'h0000, 16'h8000, 16'h0000, 16'h7FFF, 1'b1);
    chk("neg_R", o_sampleR, expNeg);
    chk("neg_L", o_sampleL, 16'h0000);
    pop1();
    frame(16'h0000, 16'h8000, 16'h0000, 16'h7FFF, 1'b0);
    chk("dis_R", o_sampleR, 16'h8000);
    pop1();
    chk("empty_level", 16'(o_level), 16'h0);

    // FIFO full: five frames, fifth is dropped
    for (int n = 1; n <= 5; n++) frame(16'(n), 16'(16'h0100 + n), 16'h0, 16'h0, 1'b0);
    chk("full_level", 16'(o_level), 16'h4);
    chk("full_ovf", 16'(o_overflow), 16'h1);
    for (int n = 1; n <= 4; n++) begin
      chk("fifo_L", o_sampleL, 16'(n));
      chk("fifo_R", o_sampleR, 16'(16'h0100 + n));
      pop1();
    end
    chk("drain_valid", 16'(o_sampleValid), 16'h0);
    chk("ovf_sticky", 16'(o_overflow), 16'h1);
    i_clrOverflow = 1'b1;
    tick();
    i_clrOverflow = 1'b0;
    chk("ovf_clr", 16'(o_overflow), 16'h0);

    // Busy collision plus capture race: 0x0100 + (0x2000*0x4000)>>15 = 0x1100
    capture(1'b0, 16'h2000);
    i_dryL = 16'h0100; i_dryR = 16'h0000; i_vLOUT = 16'h4000; i_vROUT = 16'h0000;
    i_reverbOutEnable = 1'b1; i_ctrlSendOut = 1'b1;
    tick();
    i_ctrlSendOut = 1'b0;
    capture(1'b0, 16'h7000);
    i_ctrlSendOut = 1'b1;
    tick();
    i_ctrlSendOut = 1'b0;
    tick();
    chk("coll_L", o_sampleL, 16'h1100);
    chk("coll_ovf", 16'(o_overflow), 16'h1);
    tick(); tick(); tick(); tick();
    chk("coll_level", 16'(o_level), 16'h1);
    pop1();

    // Reset during RIGHT with two entries queued
    frame(16'h0011, 16'h0022, 16'h0, 16'h0, 1'b0);
    frame(16'h0033, 16'h0044, 16'h0, 16'h0, 1'b0);
    chk("pre_level", 16'(o_level), 16'h2);
    i_ctrlSendOut = 1'b1;
    tick();
    i_ctrlSendOut = 1'b0;
    tick();
    #2 i_rst = 1'b1;
    #1;
    chk("mid_L", o_sampleL, 16'h0);
    chk("mid_R", o_sampleR, 16'h0);
    chk("mid_valid", 16'(o_sampleValid), 16'h0);
    chk("mid_level", 16'(o_level), 16'h0);
    chk("mid_busy", 16'(o_busy), 16'h0);
    chk("mid_ovf", 16'(o_overflow), 16'h0);
    tick();
    i_rst = 1'b0;
    tick();
    frame(16'h1234, 16'h5678, 16'h7FFF, 16'h7FFF, 1'b1);
    chk("post_level", 16'(o_level), 16'h1);
    chk("post_L", o_sampleL, 16'h1234);
    chk("post_R", o_sampleR, 16'h5678);
    tick(); tick(); tick(); tick();
    chk("post_once", 16'(o_level), 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
